// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM states, shift-direction codes
// common with the transmit side, and a small width helper.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, RECV, DONE} rx_state_t;

  localparam logic [1:0] SHIFT_NONE  = 2'd0;
  localparam logic [1:0] SHIFT_RIGHT = 2'd1;
  localparam logic [1:0] SHIFT_LEFT  = 2'd2;

  // Counter widths never drop below one bit, even for degenerate ranges.
  function automatic int unsigned min1(input int unsigned v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period tick counter: counts 0..cycleDiv-1 while enabled and pulses
// midTick at the bit centre and endTick on the final cycle of each period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned cycleDiv = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic midTick,
  output logic endTick
);

  localparam int unsigned TW = min1($clog2(cycleDiv));
  localparam logic [TW-1:0] MID_CNT  = TW'(cycleDiv / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(cycleDiv - 1);

  logic [TW-1:0] tick_q, tick_d;

  assign midTick = en & ~clear & (tick_q == MID_CNT);
  assign endTick = en & ~clear & (tick_q == LAST_CNT);

  always_comb begin
    tick_d = tick_q;
    if (clear) begin
      tick_d = '0;
    end else if (en) begin
      tick_d = endTick ? '0 : tick_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_q <= '0;
    else       tick_q <= tick_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive end: start-edge detect, delay/receive FSM, LSB-first shift
// register and output word with 1-cycle valid. UART_REC_SYNC_EN adds 2-flop input synchronisers.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned packetSize      = 16,
  parameter int unsigned cycleDiv        = 100,
  parameter int unsigned propDelayOffset = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bsIn,
  input  logic                  sendSig,
  output logic [packetSize-1:0] dataOut,
  output logic                  dValid,
  output logic                  busy
);

  localparam int unsigned BW = min1($clog2(packetSize + 1));
  localparam int unsigned DW = min1($clog2(propDelayOffset + 1));
  localparam logic [BW-1:0] BIT_LAST = BW'(packetSize - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'((propDelayOffset == 0) ? 0 : propDelayOffset - 1);
  localparam logic [1:0]    SHIFT_DIR = SHIFT_RIGHT;

  logic bs_w, ss_w;

`ifdef UART_REC_SYNC_EN
  logic [1:0] bs_sync_q, ss_sync_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bs_sync_q <= '0;
      ss_sync_q <= '1;
    end else begin
      bs_sync_q <= {bs_sync_q[0], bsIn};
      ss_sync_q <= {ss_sync_q[0], sendSig};
    end
  end
  assign bs_w = bs_sync_q[1];
  assign ss_w = ss_sync_q[1];
`else
  assign bs_w = bsIn;
  assign ss_w = sendSig;
`endif

  rx_state_t             state_q, state_d;
  logic                  ss_hist_q;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DW-1:0]         dly_q, dly_d;
  logic [packetSize-1:0] shift_q, shift_d, shifted;
  logic [packetSize-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  start, timer_clr, midTick, endTick;

  assign start   = ss_w & ~ss_hist_q;
  assign busy    = (state_q == DELAY) || (state_q == RECV);
  assign dataOut = data_q;
  assign dValid  = valid_q;

  // Timer is cleared on the start edge and then free-runs through DELAY and RECV,
  // so bit centres land at whole periods after the start plus half a period.
  uart_bit_timer #(.cycleDiv(cycleDiv)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clr),
    .en     (busy),
    .midTick(midTick),
    .endTick(endTick)
  );

  always_comb begin
    case (SHIFT_DIR)
      SHIFT_LEFT: shifted = {shift_q[packetSize-2:0], bs_w};
      SHIFT_NONE: shifted = shift_q;
      default:    shifted = {bs_w, shift_q[packetSize-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    dly_d     = dly_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    timer_clr = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        timer_clr = 1'b1;
        bit_d     = '0;
        dly_d     = '0;
        state_d   = (propDelayOffset == 0) ? RECV : DELAY;
      end
      DELAY: if (endTick) begin
        if (dly_q == DLY_LAST) state_d = RECV;
        else                   dly_d   = dly_q + DW'(1);
      end
      RECV: if (midTick) begin
        shift_d = shifted;
        if (bit_q == BIT_LAST) state_d = DONE;
        else                   bit_d   = bit_q + BW'(1);
      end
      DONE: begin
        data_d  = shift_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ss_hist_q <= 1'b1;
      bit_q     <= '0;
      dly_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_hist_q <= ss_w;
      bit_q     <= bit_d;
      dly_q     <= dly_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

endmodule
